// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 scan-code constants and state types
// Used by the PS/2 key tracker and by key_to_pitch.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
  localparam logic [7:0] PS2_NO_KEY     = 8'h00;
  localparam int         PS2_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    DEC_MAKE,
    DEC_BREAK_PEND
  } dec_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 synchronizer, edge detect, frame receiver and timeout
// Odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] LAST_BIT = 3'(PS2_DATA_BITS - 1);

  logic      clk_sync1_q, clk_sync1_d, clk_sync2_q, clk_sync2_d, clk_prev_q, clk_prev_d;
  logic      dat_sync1_q, dat_sync1_d, dat_sync2_q, dat_sync2_d;
  rx_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       byte_valid_q, byte_valid_d;
  logic       err_q, err_d;
  logic       fall;
  logic       parity_ok;

  assign fall = clk_prev_q & ~clk_sync2_q;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  assign parity_ok = ^{shift_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    clk_sync1_d  = ps2_clk;
    clk_sync2_d  = clk_sync1_q;
    clk_prev_d   = clk_sync2_q;
    dat_sync1_d  = ps2_data;
    dat_sync2_d  = dat_sync1_q;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tmo_cnt_d    = '0;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    err_d        = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d        = par_q;
`endif

    case (state_q)
      RX_IDLE: begin
        if (fall && !dat_sync2_q) begin
          state_d   = RX_DATA;
          bit_cnt_d = '0;
        end
      end
      RX_DATA: begin
        if (fall) begin
          shift_d   = {dat_sync2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) state_d = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          par_d   = dat_sync2_q;
`endif
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall) begin
          state_d = RX_IDLE;
          if (dat_sync2_q && parity_ok) begin
            rx_byte_d    = shift_q;
            byte_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // A falling edge restarts the count; reaching the limit abandons the partial frame.
    if (state_q != RX_IDLE && !fall) begin
      if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = RX_IDLE;
        err_d   = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync1_q  <= 1'b1;
      clk_sync2_q  <= 1'b1;
      clk_prev_q   <= 1'b1;
      dat_sync1_q  <= 1'b1;
      dat_sync2_q  <= 1'b1;
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tmo_cnt_q    <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q        <= 1'b0;
`endif
    end else begin
      clk_sync1_q  <= clk_sync1_d;
      clk_sync2_q  <= clk_sync2_d;
      clk_prev_q   <= clk_prev_d;
      dat_sync1_q  <= dat_sync1_d;
      dat_sync2_q  <= dat_sync2_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      err_q        <= err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q        <= par_d;
`endif
    end
  end

  assign rx_byte    = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign err        = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 make/break decoder tracking the last-pressed key
// Parity checking in the receiver is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_code,
  output logic       code_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  dec_state_t dec_q, dec_d;
  logic [7:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(rx_valid),
    .err       (rx_err)
  );

  // The receiver never flags a byte and an error together, so the outputs stay exclusive.
  always_comb begin
    dec_d   = dec_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = rx_err;

    if (rx_valid && rx_byte != PS2_EXT_CODE) begin
      case (dec_q)
        DEC_MAKE: begin
          if (rx_byte == PS2_BREAK_CODE) begin
            dec_d = DEC_BREAK_PEND;
          end else begin
            code_d  = rx_byte;
            valid_d = 1'b1;
          end
        end
        DEC_BREAK_PEND: begin
          if (rx_byte == code_q) code_d = PS2_NO_KEY;
          dec_d = DEC_MAKE;
        end
        default: dec_d = DEC_MAKE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_q   <= DEC_MAKE;
      code_q  <= PS2_NO_KEY;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dec_q   <= dec_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ps2_code   = code_q;
  assign code_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - self-checking bench for ps2_key_tracker
// Expectations follow PS2_PARITY_CHECK_EN the same way the design does.
module tb_ps2_key_tracker;

  localparam int T    = 200;
  localparam int HALF = 10;
  localparam int LAT  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2_code;
  logic       code_valid;
  logic       frame_err;

  ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_code  (ps2_code),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int n_valid = 0;
  int n_err = 0;

  typedef struct {
    int         at;
    bit         is_err;
    logic [7:0] b;
  } ev_t;
  ev_t evq[$];

  logic [7:0] m_code = 8'h00;
  bit         m_brk = 1'b0;
  int         nb = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_par = 1'b0;
  int         last_edge = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_byte(input logic [7:0] b);
    if (b == 8'hE0) return 1'b0;
    if (!m_brk) begin
      if (b == 8'hF0) begin
        m_brk = 1'b1;
        return 1'b0;
      end
      m_code = b;
      return 1'b1;
    end
    if (b == m_code) m_code = 8'h00;
    m_brk = 1'b0;
    return 1'b0;
  endfunction

  // Frame bookkeeping at the bit level; result lands LAT cycles after the stop edge is driven.
  task automatic model_edge(input logic d);
    bit ok;
    if (nb == 0) begin
      if (d == 1'b0) nb = 1;
    end else if (nb <= 8) begin
      m_data[nb-1] = d;
      nb++;
    end else if (nb == 9) begin
      m_par = d;
      nb++;
    end else begin
      ok = d;
`ifdef PS2_PARITY_CHECK_EN
      ok = ok && (^{m_data, m_par});
`endif
      evq.push_back('{at: cyc + LAT, is_err: !ok, b: m_data});
      nb = 0;
    end
    last_edge = cyc;
  endtask

  task automatic ps2_edge(input logic d);
    @(negedge clk);
    ps2_data = d;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    model_edge(d);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    ps2_edge(1'b0);
    for (int i = 0; i < 8; i++) ps2_edge(b[i]);
    ps2_edge((~^b) ^ bad_par);
    ps2_edge(!bad_stop);
    repeat (8) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    @(posedge clk);
    n_valid = 0;
    n_err = 0;
  endtask

  task automatic do_reset();
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_code = 8'h00;
    m_brk = 1'b0;
    nb = 0;
    evq.delete();
    @(negedge clk);
    check("rst_code", ps2_code, 8'h00);
    check("rst_valid", code_valid, 0);
    check("rst_err", frame_err, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [7:0] e_code;
    logic       e_v;
    logic       e_e;
    ev_t        ev;
    e_v = 1'b0;
    e_e = 1'b0;
    if (!reset) begin
      e_code = 8'h00;
    end else begin
      if (nb != 0 && cyc == last_edge + LAT + T) begin
        e_e = 1'b1;
        nb = 0;
      end
      while (evq.size() > 0 && evq[0].at <= cyc) begin
        ev = evq.pop_front();
        if (ev.is_err) e_e = 1'b1;
        else if (model_byte(ev.b)) e_v = 1'b1;
      end
      e_code = m_code;
    end
    vectors++;
    if (ps2_code !== e_code || code_valid !== e_v || frame_err !== e_e) begin
      miscompares++;
      $display("FAIL cycle %0d: code=%h valid=%b err=%b, expected code=%h valid=%b err=%b",
               cyc, ps2_code, code_valid, frame_err, e_code, e_v, e_e);
    end
    if (code_valid) n_valid++;
    if (frame_err) n_err++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("idle_code", ps2_code, 8'h00);

    // single press, then release
    clear_counts();
    send(8'h1C);
    check("press_code", ps2_code, 8'h1C);
    check("press_pulses", n_valid, 1);
    send(8'hF0);
    send(8'h1C);
    check("release_code", ps2_code, 8'h00);
    check("release_pulses", n_valid, 1);

    // last-pressed-wins
    do_reset();
    clear_counts();
    send(8'h1C);
    send(8'h32);
    send(8'hF0);
    send(8'h1C);
    check("overlap_code", ps2_code, 8'h32);
    check("overlap_pulses", n_valid, 2);

    // inverted parity
    clear_counts();
    send_frame(8'h23, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("parity_code", ps2_code, 8'h32);
    check("parity_err", n_err, 1);
`else
    check("parity_code", ps2_code, 8'h23);
    check("parity_err", n_err, 0);
`endif

    // extended prefix dropped, typematic repeat, extended release
    clear_counts();
    send(8'hE0);
    send(8'h75);
    send(8'h75);
    check("ext_code", ps2_code, 8'h75);
    check("typematic_pulses", n_valid, 2);
    send(8'hE0);
    send(8'hF0);
    send(8'hE0);
    send(8'h75);
    check("ext_release_code", ps2_code, 8'h00);

    // start bit sampled high is ignored
    clear_counts();
    ps2_edge(1'b1);
    repeat (10) @(negedge clk);
    check("bad_start_valid", n_valid, 0);
    check("bad_start_err", n_err, 0);

    // stop bit error
    send(8'h2B);
    clear_counts();
    send_frame(8'h44, 1'b0, 1'b1);
    check("stop_err", n_err, 1);
    check("stop_code", ps2_code, 8'h2B);
    check("stop_valid", n_valid, 0);

    // timeout on a partial frame, then recovery
    clear_counts();
    for (int i = 0; i < 5; i++) ps2_edge(i[0]);
    repeat (T + 20) @(negedge clk);
    check("timeout_err", n_err, 1);
    send(8'h1B);
    check("after_timeout_code", ps2_code, 8'h1B);

    // reset after the 4th data bit
    ps2_edge(1'b0);
    for (int i = 0; i < 4; i++) ps2_edge(1'b1);
    do_reset();
    check("post_reset_code", ps2_code, 8'h00);
    clear_counts();
    send(8'h15);
    check("post_reset_frame", ps2_code, 8'h15);
    check("post_reset_pulses", n_valid, 1);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
